// File: rtl/td4x_core_if.sv
// Instruction-fetch bus between td4x_core (master) and the external program store (slave).
// The store answers a held imem_req with imem_ack plus the instruction word on imem_data.
interface td4x_core_if #(
   parameter int W  = 4,
   parameter int AW = 4
);
   logic [AW-1:0]  imem_addr;
   logic           imem_req;
   logic           imem_ack;
   logic [W+3:0]   imem_data;

   modport master (output imem_addr, output imem_req, input imem_ack, input imem_data);
   modport slave  (input imem_addr, input imem_req, output imem_ack, output imem_data);
endinterface

// File: rtl/td4x_core.sv
// Parametrised TD4-class CPU core with an external req/ack fetch bus and a strobed output port.
// Optional HLT instruction and HALT state are enabled by defining TD4X_HALT_EN.
module td4x_core #(
   parameter int W  = 4,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic [W-1:0]  in,
   output logic [W-1:0]  out,
   output logic          out_stb,
   input  logic          run,
   output logic          halted,
   td4x_core_if.master   imem
);

   // state | meaning
   // FETCH | request instruction at PC, wait for imem_ack
   // EXEC  | execute IR: one register write, update C and PC
   // HALT  | stopped after HLT until run=1 (TD4X_HALT_EN only)
   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   logic [1:0]    state;
   logic [W-1:0]  a, b;
   logic [AW-1:0] pc;
   logic          c;
   logic [W+3:0]  ir;

   logic [3:0]    opcode;
   logic [W-1:0]  imm, operand;
   logic [W:0]    sum;
   logic [AW-1:0] pc_next;
   logic          wr_a, wr_b, wr_out, jump, hlt;

   assign opcode = ir[W+3:W];
   assign imm    = ir[W-1:0];

   always_comb begin
      operand = '0;
      wr_a    = 1'b0;
      wr_b    = 1'b0;
      wr_out  = 1'b0;
      jump    = 1'b0;
      hlt     = 1'b0;
      case (opcode)
         4'b0000: begin operand = a;  wr_a = 1'b1; end
         4'b0101: begin operand = b;  wr_b = 1'b1; end
         4'b0011: wr_a = 1'b1;
         4'b0111: wr_b = 1'b1;
         4'b0001: begin operand = b;  wr_a = 1'b1; end
         4'b0100: begin operand = a;  wr_b = 1'b1; end
         4'b0010: begin operand = in; wr_a = 1'b1; end
         4'b0110: begin operand = in; wr_b = 1'b1; end
         4'b1001: begin operand = b;  wr_out = 1'b1; end
         4'b1011: wr_out = 1'b1;
         4'b1111: jump = 1'b1;
         4'b1110: jump = ~c;
`ifdef TD4X_HALT_EN
         4'b1000: hlt = 1'b1;
`endif
         default: ;
      endcase
   end

   assign sum     = {1'b0, operand} + {1'b0, imm};
   // Upper immediate bits beyond AW are dropped for jump targets.
   assign pc_next = jump ? sum[AW-1:0] : pc + AW'(1);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state   <= ST_FETCH;
         a       <= '0;
         b       <= '0;
         out     <= '0;
         pc      <= '0;
         c       <= 1'b0;
         ir      <= '0;
         out_stb <= 1'b0;
      end else begin
         out_stb <= 1'b0;
         case (state)
            ST_FETCH: begin
               if (imem.imem_ack) begin
                  ir    <= imem.imem_data;
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               c  <= hlt ? 1'b0 : sum[W];
               pc <= pc_next;
               if (wr_a) a <= sum[W-1:0];
               if (wr_b) b <= sum[W-1:0];
               if (wr_out) begin
                  out     <= sum[W-1:0];
                  out_stb <= 1'b1;
               end
               state <= hlt ? ST_HALT : ST_FETCH;
            end
`ifdef TD4X_HALT_EN
            ST_HALT: begin
               if (run) state <= ST_FETCH;
            end
`endif
            default: state <= ST_FETCH;
         endcase
      end
   end

   assign imem.imem_req  = (state == ST_FETCH);
   assign imem.imem_addr = pc;

`ifdef TD4X_HALT_EN
   assign halted = (state == ST_HALT);
`else
   logic run_unused;
   assign run_unused = run;
   assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_td4x_core.sv
// Self-checking bench for td4x_core: directed program plus randomized instruction stream
// compared against an instruction-level reference model.
module tb_td4x_core;
   localparam int W  = 4;
   localparam int AW = 4;
   localparam int MW = 1 << W;
   localparam int MA = 1 << AW;
`ifdef TD4X_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic          clk;
   logic          rst_b;
   logic [W-1:0]  in_port;
   logic [W-1:0]  out_port;
   logic          out_stb;
   logic          run;
   logic          halted;

   logic [7:0]    in8;
   logic [7:0]    out8;
   logic          out_stb8;
   logic          run8;
   logic          halted8;

   int n_cmp = 0;
   int n_err = 0;

   int m_a, m_b, m_out, m_pc, m_c;
   int m_stb;
   int m_halted;

   td4x_core_if #(.W(W), .AW(AW)) bus ();
   td4x_core_if #(.W(8), .AW(4))  bus8 ();

   td4x_core #(.W(W), .AW(AW)) dut (
      .clk(clk), .rst_b(rst_b), .in(in_port), .out(out_port), .out_stb(out_stb),
      .run(run), .halted(halted), .imem(bus.master)
   );

   td4x_core #(.W(8), .AW(4)) dut8 (
      .clk(clk), .rst_b(rst_b), .in(in8), .out(out8), .out_stb(out_stb8),
      .run(run8), .halted(halted8), .imem(bus8.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_a = 0; m_b = 0; m_out = 0; m_pc = 0; m_c = 0; m_stb = 0; m_halted = 0;
   endtask

   // Instruction-level reference: operand + imm, destination, carry, next PC.
   task automatic model_exec(input logic [7:0] ins, input int in_val);
      int op, imm, s, dest;
      bit jmp;
      op = int'(ins[7:4]);
      imm = int'(ins[3:0]);
      dest = 0;
      jmp = 1'b0;
      s = imm;
      case (op)
         0:  begin s = m_a + imm;    dest = 1; end
         5:  begin s = m_b + imm;    dest = 2; end
         3:  dest = 1;
         7:  dest = 2;
         1:  begin s = m_b + imm;    dest = 1; end
         4:  begin s = m_a + imm;    dest = 2; end
         2:  begin s = in_val + imm; dest = 1; end
         6:  begin s = in_val + imm; dest = 2; end
         9:  begin s = m_b + imm;    dest = 3; end
         11: dest = 3;
         15: jmp = 1'b1;
         14: jmp = (m_c == 0);
         default: ;
      endcase
      case (dest)
         1: m_a = s % MW;
         2: m_b = s % MW;
         3: m_out = s % MW;
         default: ;
      endcase
      m_stb = (dest == 3) ? 1 : 0;
      m_c = (s >= MW) ? 1 : 0;
      m_pc = jmp ? (s % MA) : ((m_pc + 1) % MA);
      if (HALT_EN && op == 8) begin
         m_c = 0;
         m_halted = 1;
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_out"},    out_port,      m_out);
      check({tag, "_stb"},    out_stb,       m_stb);
      check({tag, "_addr"},   bus.imem_addr, m_pc);
      check({tag, "_a"},      dut.a,         m_a);
      check({tag, "_b"},      dut.b,         m_b);
      check({tag, "_c"},      dut.c,         m_c);
      check({tag, "_halted"}, halted,        m_halted);
      check({tag, "_req"},    bus.imem_req,  (m_halted != 0) ? 0 : 1);
   endtask

   // Entered at a negedge with the core in FETCH; leaves at the negedge after EXEC.
   task automatic do_instr(input string tag, input logic [7:0] ins, input int stall, input int in_val);
      in_port = W'(in_val);
      check({tag, "_fetch_req"},  bus.imem_req,  1);
      check({tag, "_fetch_addr"}, bus.imem_addr, m_pc);
      for (int i = 0; i < stall; i++) begin
         bus.imem_ack  = 1'b0;
         bus.imem_data = 8'($urandom);
         run = 1'($urandom);
         @(negedge clk);
         check({tag, "_stall_req"},  bus.imem_req,  1);
         check({tag, "_stall_addr"}, bus.imem_addr, m_pc);
         check({tag, "_stall_a"},    dut.a,         m_a);
         check({tag, "_stall_stb"},  out_stb,       0);
      end
      bus.imem_ack  = 1'b1;
      bus.imem_data = ins;
      run = 1'($urandom);
      @(negedge clk);
      check({tag, "_exec_req"}, bus.imem_req, 0);
      check({tag, "_exec_stb"}, out_stb,      0);
      bus.imem_ack  = 1'($urandom);
      bus.imem_data = 8'($urandom);
      model_exec(ins, in_val);
      @(negedge clk);
      bus.imem_ack = 1'b0;
      run = 1'b0;
      check_state(tag);
   endtask

   task automatic resume(input string tag, input int wait_cycles);
      for (int i = 0; i < wait_cycles; i++) begin
         @(negedge clk);
         check({tag, "_hold_halted"}, halted,        1);
         check({tag, "_hold_req"},    bus.imem_req,  0);
         check({tag, "_hold_addr"},   bus.imem_addr, m_pc);
      end
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      m_halted = 0;
      check({tag, "_run_halted"}, halted,        0);
      check({tag, "_run_req"},    bus.imem_req,  1);
      check({tag, "_run_addr"},   bus.imem_addr, m_pc);
   endtask

   initial begin
      logic [7:0] ins;
      rst_b = 1'b0;
      in_port = '0;
      run = 1'b0;
      bus.imem_ack = 1'b0;
      bus.imem_data = '0;
      in8 = '0;
      run8 = 1'b0;
      bus8.imem_ack = 1'b1;
      bus8.imem_data = 12'hF3A;
      model_reset();
      #1;
      check_state("por");
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      check_state("release");

      // carry and conditional jump
      do_instr("mov_a3",   8'h33, 0, 0);
      do_instr("add_a14",  8'h0E, 0, 0);
      check("carry_a", dut.a, 1);
      check("carry_c", dut.c, 1);
      do_instr("jnc_nt",   8'hE0, 0, 0);
      check("jnc_nt_addr", bus.imem_addr, 3);
      do_instr("add_a1",   8'h01, 0, 0);
      do_instr("jnc_t",    8'hE0, 0, 0);
      check("jnc_t_addr", bus.imem_addr, 0);

      // I/O, stall at PC=2, halt at PC=4
      do_instr("in_b",     8'h60, 0, 9);
      do_instr("out_b",    8'h90, 0, 3);
      check("out_b_val", out_port, 9);
      do_instr("out_5",    8'hB5, 5, 0);
      check("out_5_val", out_port, 5);
      do_instr("mov_b_a",  8'h40, 0, 0);
      do_instr("hlt",      8'h80, 0, 0);
      if (m_halted != 0) resume("halt", 10);
      check("after_hlt_addr", bus.imem_addr, 5);

      // PC wrap
      do_instr("jmp15",    8'hFF, 0, 0);
      check("jmp15_addr", bus.imem_addr, 15);
      do_instr("wrap_add", 8'h01, 0, 0);
      check("wrap_addr", bus.imem_addr, 0);

      // async reset in FETCH while out_stb is high
      do_instr("pre_rst",  8'h90, 0, 0);
      rst_b = 1'b0;
      #1;
      model_reset();
      check_state("mid_rst");
      @(negedge clk);
      rst_b = 1'b1;
      check_state("post_rst");

      // randomized instruction stream
      for (int n = 0; n < 300; n++) begin
         ins = 8'($urandom);
         do_instr("rand", ins, int'($urandom_range(0, 2)), int'($urandom_range(0, MW - 1)));
         if (m_halted != 0) resume("rand_halt", int'($urandom_range(0, 3)));
      end

      check("w8_jmp_addr", bus8.imem_addr, 4'hA);
      check("w8_out",      out8,           0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/td4x_core.md
# td4x_core

Parametrised successor to the 4-bit TD4-class CPU core. Data width and program-address width are generic. The program store moves out of the core behind a req/ack fetch handshake, and the output port gains a write strobe. It sits between an external instruction memory (ROM/RAM/bus bridge) and simple GPIO-style in/out ports. An optional halt instruction is available.

## Interface
- W, 4, data/immediate width; A, B, OUT register width
- AW, 4, program counter width; AW <= W
- clk  in  1  rising-edge clock
- rst_b  in  1  asynchronous, active-low reset
- in  in  W  input port, sampled in EXEC
- out  out  W  output port register
- out_stb  out  1  one-cycle pulse when `out` is written
- imem_addr  out  AW  fetch address (= PC)
- imem_req  out  1  fetch request
- imem_ack  in  1  fetch data valid
- imem_data  in  W+4  instruction: [W+3:W] opcode, [W-1:0] immediate
- run  in  1  resume from HALT (TD4X_HALT_EN only; ignored otherwise)
- halted  out  1  core in HALT state

## Operation
- States: FETCH, EXEC, HALT (HALT exists only with the macro).
- FETCH: imem_req=1, imem_addr=PC. On a clock edge with imem_ack=1: IR <= imem_data, go to EXEC. With imem_ack=0: hold, no state change.
- EXEC: imem_req=0. Decode IR, perform at most one register write, update C and PC, then go to FETCH (or HALT).
- ALU: {cout, sum} = operand + imm, W-bit sum, carry-in 0.
- Operand select: A, B, in, or zero.
- C <= cout on every EXEC, for every opcode. Zero-operand opcodes therefore clear C.
- Opcodes (operand → destination):
  - 0000 ADD A,imm (A → A)
  - 0101 ADD B,imm (B → B)
  - 0011 MOV A,imm (0 → A)
  - 0111 MOV B,imm (0 → B)
  - 0001 MOV A,B (B → A, imm expected 0; sum used as-is)
  - 0100 MOV B,A (A → B)
  - 0010 IN A (in → A)
  - 0110 IN B (in → B)
  - 1001 OUT B (B → OUT)
  - 1011 OUT imm (0 → OUT)
  - 1111 JMP imm (0 → PC)
  - 1110 JNC imm (0 → PC only if C==0 before this EXEC)
- Jump target = sum[AW-1:0]. Upper immediate bits are ignored.
- Non-jump (or not-taken JNC): PC <= PC+1 mod 2^AW. 2^AW-1 wraps to 0.
- Any OUT write pulses out_stb for the EXEC cycle's following clock (registered, high exactly one cycle).
- Undefined opcodes: NOP. No register write, PC+1, C <= cout of 0+imm (= 0).

## Timing
- Minimum two cycles per instruction (FETCH with immediate ack, then EXEC). Each extra cycle of ack wait adds one.
- Register and C updates become visible the cycle after EXEC. A JNC in the next instruction sees the C from the previous EXEC.
- imem_addr and imem_req are decoded from state/PC only; no combinational path from imem_ack.
- Reset (async, any state, including mid-fetch): A=B=out=0, PC=0, C=0, IR=0, out_stb=0, halted=0, state=FETCH. A pending fetch is abandoned, and the first request after release is to address 0.
- imem_ack outside FETCH is ignored.

## Configuration
- TD4X_HALT_EN defined:
  - Opcode 1000 = HLT: PC <= PC+1, C <= 0, then state=HALT.
  - In HALT: halted=1, imem_req=0, all registers hold.
  - run=1 sampled on a clock edge → FETCH at the incremented PC.
  - run=1 during FETCH/EXEC has no effect.
- Not defined: opcode 1000 is an undefined-opcode NOP, halted is tied to 0, run is unused, and no HALT state exists.

## Test plan
- Reset: assert rst_b=0 mid-FETCH with imem_req=1 → immediately A=B=out=0, C=0, halted=0, out_stb=0; after release imem_addr=0, imem_req=1.
- Carry/JNC (W=4): MOV A,3; ADD A,14 → A=1, C=1; JNC 0 not taken → next imem_addr=3; then ADD A,1 (C=0); JNC 0 → imem_addr=0.
- I/O: in=9; IN B; OUT B → out=9, out_stb high exactly one cycle; OUT 5 → out=5, second one-cycle pulse.
- Fetch stall: hold imem_ack=0 for 5 cycles in FETCH at PC=2 → imem_req stays 1, imem_addr stays 2, no register/PC change; ack on cycle 6 → instruction executes next cycle.
- Wrap and width: JMP 15 → PC=15; ADD A,1 at 15 → next imem_addr=0. With W=8, AW=4: JMP 0x3A → imem_addr=0xA.
- Halt (macro on): HLT at PC=4 → halted=1, imem_req=0 for 10 cycles; run pulse → imem_addr=5, halted=0. Macro off: same program treats HLT as NOP and fetches address 5 immediately.
